// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, 5..9 data bits, 1/2 stop bits, majority vote, receive FIFO.
// Define UART_RX_PARITY_EN to expect and check a parity bit after the data bits.
module uart_rx_fifo #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RX,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          RC,
  input  logic                          read_complete,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clear_err
);

  localparam int TICK_DIV = CLK_FREQUENCY / (BAUD_RATE * 16) - 1;
  localparam int DIV_W    = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic                 rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  state_t               state_q, state_d;
  logic [3:0]           tc_q, tc_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 fpend_q, fpend_d;
  logic                 bit_v;
  logic                 push, frame_set, parity_set;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic ppend_q, ppend_d;
  logic par_exp;
  assign par_exp = (^shift_q) ^ ODD_BIT;
`endif

  assign tick  = (div_q == DIV_W'(TICK_DIV));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);
  // Majority of the tc=7, tc=8 samples and the live sample at tc=9
  assign bit_v = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    fpend_d    = fpend_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    ppend_d    = ppend_q;
`endif
    if (tick) begin
      if (state_q == S_IDLE) begin
        tc_d = 4'd0;
        if (!rx_s_q) begin
          state_d    = S_START;
          fpend_d    = 1'b0;
          stop_idx_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          ppend_d    = 1'b0;
`endif
        end
      end else begin
        tc_d = tc_q + 4'd1;
        if (tc_q == 4'd7) samp_d[0] = rx_s_q;
        if (tc_q == 4'd8) samp_d[1] = rx_s_q;
        case (state_q)
          S_START: begin
            if (tc_q == 4'd9 && bit_v) begin
              state_d = S_IDLE;
              tc_d    = 4'd0;
            end else if (tc_q == 4'd15) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end
          end
          S_DATA: begin
            if (tc_q == 4'd9) begin
              shift_d[bit_idx_q] = bit_v;
            end else if (tc_q == 4'd15) begin
              if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_d = S_PARITY;
`else
                state_d = S_STOP;
`endif
              end else begin
                bit_idx_d = bit_idx_q + IDX_W'(1);
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tc_q == 4'd9 && bit_v != par_exp) ppend_d = 1'b1;
            else if (tc_q == 4'd15) state_d = S_STOP;
          end
`endif
          S_STOP: begin
            if (tc_q == 4'd9) begin
              if (!bit_v) fpend_d = 1'b1;
              // Finish at mid-stop so a following start edge is never missed
              if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                push      = 1'b1;
                frame_set = fpend_q | ~bit_v;
`ifdef UART_RX_PARITY_EN
                parity_set = ppend_q;
`endif
                state_d   = S_IDLE;
                tc_d      = 4'd0;
              end
            end else if (tc_q == 4'd15) begin
              stop_idx_d = 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
            tc_d    = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      div_q      <= '0;
      state_q    <= S_IDLE;
      tc_q       <= 4'd0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      samp_q     <= 2'b11;
      fpend_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ppend_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= RX;
      rx_s_q     <= rx_meta_q;
      div_q      <= div_d;
      state_q    <= state_d;
      tc_q       <= tc_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      fpend_q    <= fpend_d;
`ifdef UART_RX_PARITY_EN
      ppend_q    <= ppend_d;
`endif
    end
  end

  // Receive FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 pop, full, push_ok;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 parity_err_q, parity_err_d;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = read_complete & (count_q != '0);
  assign push_ok = push & (~full | pop);

  always_comb begin
    wr_ptr_d     = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    frame_err_d  = (push & frame_set) | (frame_err_q & ~clear_err);
    parity_err_d = (push & parity_set) | (parity_err_q & ~clear_err);
    overrun_d    = (push & full & ~pop) | (overrun_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign RC         = (count_q != '0);
  assign data_out   = RC ? mem[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  // Constant 0 for every legal PARITY_ODD value
  assign parity_err = parity_err_q & (PARITY_ODD < 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: serial frames driven bit by bit, checked against a queue model.
module tb_uart_rx_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 8;
  localparam int PODD  = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          RX;
  logic [DB-1:0] data_out;
  logic          RC;
  logic          read_complete;
  logic [3:0]    fifo_count;
  logic          frame_err, parity_err, overrun;
  logic          clear_err;

  uart_rx_fifo #(
    .CLK_FREQUENCY(16000000), .BAUD_RATE(1000000), .DATA_BITS(DB),
    .STOP_BITS(1), .PARITY_ODD(PODD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .RX(RX), .data_out(data_out), .RC(RC),
    .read_complete(read_complete), .fifo_count(fifo_count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of received bytes plus sticky flags
  logic [DB-1:0] exp_q[$];
  logic exp_fe, exp_pe, exp_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rc"}, 32'(RC), 32'(exp_q.size() != 0));
    check({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
    if (exp_q.size() != 0) check({tag, ".data"}, 32'(data_out), 32'(exp_q[0]));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_fe));
    check({tag, ".parity_err"}, 32'(parity_err), 32'(exp_pe));
    check({tag, ".overrun"}, 32'(overrun), 32'(exp_ov));
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    exp_ov = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    RX = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // par_ok only matters when the parity bit is part of the frame
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_ok);
    logic perr;
    perr = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    begin
      int ones;
      logic pbit;
      ones = $countones(d);
      pbit = ((ones % 2) == 1) ? 1'b1 : 1'b0;
      if (PODD != 0) pbit = ~pbit;
      if (!par_ok) pbit = ~pbit;
      perr = ~par_ok;
      send_bit(pbit);
    end
`endif
    send_bit(stop_v);
    RX = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ov = 1'b1;
    if (!stop_v) exp_fe = 1'b1;
    if (perr) exp_pe = 1'b1;
    $display("frame %02h stop=%0b par_ok=%0b -> count=%0d", d, stop_v, par_ok, fifo_count);
  endtask

  task automatic pop_one(input string tag);
    check({tag, ".pop_data"}, 32'(data_out), 32'(exp_q[0]));
    read_complete = 1'b1;
    @(negedge clk);
    read_complete = 1'b0;
    $display("pop %02h -> count=%0d", exp_q[0], fifo_count);
    void'(exp_q.pop_front());
    check_state(tag);
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    exp_ov = 1'b0;
    $display("clear_err -> fe=%0b pe=%0b ov=%0b", frame_err, parity_err, overrun);
  endtask

  initial begin
    RX = 1'b1;
    read_complete = 1'b0;
    clear_err = 1'b0;
    reset = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    check("reset.data_out", 32'(data_out), 32'h0);
    check_state("reset");
    reset = 1'b1;
    idle(8);

    // Single frame then pop
    send_frame(8'hA5, 1'b1, 1'b1);
    check_state("a5");
    pop_one("a5_pop");

    // Short glitch must be rejected
    RX = 1'b0;
    repeat (6) @(negedge clk);
    idle(40);
    $display("glitch 6 clk -> count=%0d", fifo_count);
    check_state("false_start");

    // Nine frames into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      idle($urandom_range(0, 3));
    end
    check_state("overrun");
    while (exp_q.size() != 0) pop_one("drain");
    do_clear();
    check_state("overrun_clr");

    // Stop bit held low
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(30);
    check_state("frame_err");
    do_clear();
    check_state("frame_clr");
    pop_one("frame_pop");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check_state("par_bad");
    do_clear();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check_state("par_good");
    while (exp_q.size() != 0) pop_one("par_drain");
`endif

    // Randomized mix of frames, pops and clears
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        logic stop_v, par_ok;
        stop_v = ($urandom_range(0, 7) != 0);
        par_ok = ($urandom_range(0, 7) != 0);
        send_frame(8'($urandom), stop_v, par_ok);
        idle(stop_v ? $urandom_range(0, 20) : 30);
        check_state("rand_frame");
      end else if (r <= 8) begin
        if (exp_q.size() != 0) pop_one("rand_pop");
      end else begin
        do_clear();
        check_state("rand_clear");
      end
    end
    while (exp_q.size() != 0) pop_one("rand_drain");

    // Reset in the middle of the data bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    RX = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    $display("reset mid-frame -> count=%0d", fifo_count);
    check_state("mid_reset");
    reset = 1'b1;
    idle(8);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(4);
    check_state("after_reset");
    check("after_reset.count1", 32'(fifo_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver that succeeds the single-byte 8N1 receiver. Supports 5–9 data bits, 1 or 2 stop bits and optional parity, with 16x oversampling, majority-vote sampling, false-start rejection and a receive FIFO. It sits between the RX pin and the host logic, which pops bytes through the existing `data_out`/`RC`/`read_complete` handshake.

## Interface
- `CLK_FREQUENCY`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in baud.
- `DATA_BITS`, 8: data bits per frame, 5..9, sent LSB first.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Used only with `UART_RX_PARITY_EN`.
- `FIFO_DEPTH`, 8: number of FIFO entries; a power of 2, minimum 2.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-low; 0 resets the block.
- `RX` input, 1 bit: serial line, idle high, asynchronous to `clk`.
- `data_out` output, `DATA_BITS` bits: FIFO head byte, valid only while `RC`=1.
- `RC` output, 1 bit: FIFO is non-empty.
- `read_complete` input, 1 bit: pops the head entry in the same cycle; ignored when `RC`=0.
- `fifo_count` output, clog2(`FIFO_DEPTH`)+1 bits: current occupancy.
- `frame_err` output, 1 bit: sticky; set when any stop-bit sample reads 0.
- `parity_err` output, 1 bit: sticky; set on a parity mismatch. Tied to 0 without the macro.
- `overrun` output, 1 bit: sticky; set when a byte is dropped because the FIFO is full.
- `clear_err` input, 1 bit: clears all three sticky flags.

## Operation
- `RX` passes through a 2-flop synchronizer (`rx_s`) that resets to 1. All decisions below use `rx_s`.
- Tick generator: divider counts 0..`TICK_DIV`, where `TICK_DIV` = `CLK_FREQUENCY`/(`BAUD_RATE`*16) − 1 (integer division).
  - Emits a one-cycle `tick` on wrap.
  - Free-running; it is not phase-reset on a start edge.
- Per-bit sampling: a tick counter `tc` runs 0..15. The bit value is the majority of the samples at `tc` = 7, 8 and 9. The bit is decided at `tc`=9.
- State machine (states IDLE, START, DATA, PARITY, STOP):
  - IDLE: `tc`=0. `rx_s`=0 on a tick → START.
  - START: the majority at `tc`=9 must be 0, else false start → IDLE with nothing recorded. On `tc`=15 → DATA with bit index 0.
  - DATA: the decided bit goes to shift position [index]. After bit `DATA_BITS`−1 at `tc`=15 → PARITY if the macro is defined, else STOP.
  - PARITY: compare the decided bit with the computed parity; a mismatch latches a pending parity error for this frame. At `tc`=15 → STOP.
  - STOP: each stop bit is decided at `tc`=9; a 0 latches a pending frame error.
    - At the final stop bit's `tc`=9 the byte is pushed, the pending errors are ORed into the sticky flags, and the state → IDLE.
    - The remaining half stop bit is not waited for, so back-to-back frames are received.
- Bytes with frame or parity errors are still pushed into the FIFO.
- FIFO behaviour:
  - Show-ahead: `data_out` = head entry combinationally from the registered array.
  - Push and pop in the same cycle: both take effect and the count is unchanged.
  - Push when full with no pop: the byte is discarded and `overrun` is set.
  - Push when full with a pop in the same cycle: the push is accepted.
  - Pointers are clog2(`FIFO_DEPTH`) bits wide and wrap naturally.
- Sticky flags: if a set and `clear_err` occur in the same cycle, set wins.

## Timing
- Reset values: `RC`=0, `data_out`=0, `fifo_count`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, state IDLE, synchronizer flops=1, divider=0.
- Reset is asynchronous and applies in any state. A frame in progress is discarded and the FIFO is emptied.
- Start detection latency: 2 synchronizer cycles plus up to 1 tick after the falling edge.
- Push point: the `tick` at `tc`=9 of the last stop bit. `RC` and `fifo_count` update on the following edge.
- `read_complete` asserted at edge N: the new head appears on `data_out` after edge N. `RC` falls after edge N if that entry was the last.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists and a parity bit is expected after the data bits.
  - `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - No parity logic is compiled and no parity bit is expected.
  - `parity_err` is constant 0.

## Test plan
All scenarios use `CLK_FREQUENCY`=16000000 and `BAUD_RATE`=1000000, giving `TICK_DIV`=0 and 16 clk per bit.
- Reset then send 0xA5 (8N1) → `RC`=1, `data_out`=0xA5, `fifo_count`=1, all error flags 0. Then `read_complete` for 1 cycle → `RC`=0.
- 0-pulse of 6 clk on idle `RX` → false start; `RC` stays 0 and no flags are set.
- Send 9 frames 0x01..0x09 with `FIFO_DEPTH`=8 and no pops → `fifo_count`=8, `overrun`=1; popping returns 0x01..0x08.
- Frame 0x3C with the stop bit held 0 → byte 0x3C is pushed and `frame_err`=1. Pulse `clear_err` → `frame_err`=0.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0, send 0x07 with parity bit 0 → `parity_err`=1. Then send 0x07 with parity bit 1 after `clear_err` → `parity_err` stays 0.
- Drive `reset`=0 mid-DATA of a frame, then release and send 0x5A → the first frame is lost and only 0x5A is received, with `fifo_count`=1.
